// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: recovers pixel/line position from an
// hs/vs/rgb stream, checks line/frame length and sync widths, reports lock,
// and samples one pixel at a run-time probe position.
module vga_timing_monitor #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned V_TOTAL     = 521,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned LOCK_FRAMES = 2,
  localparam int unsigned CNT_W      = 10,
  localparam int unsigned RGB_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic [CNT_W-1:0] probe_x,
  input  logic [CNT_W-1:0] probe_y,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             locked,
  output logic             err_line,
  output logic             err_frame,
  output logic             frame_done,
  output logic [RGB_W-1:0] probe_rgb,
  output logic             probe_valid
);

  localparam int unsigned      GOOD_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_MAX - 1'b1;
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_L = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_L = CNT_W'(V_SYNC);
  localparam logic [GOOD_W-1:0] LOCK_L  = GOOD_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    WAIT_V = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t            state, state_n;
  logic              hs_d, hs_d_n, vs_d, vs_d_n;
  logic [CNT_W-1:0]  h_cnt_n, v_cnt_n;
  logic [CNT_W-1:0]  hs_low, hs_low_n, vs_low, vs_low_n;
  logic [GOOD_W-1:0] good, good_n, good_inc;
  logic [RGB_W-1:0]  rgb_d, rgb_d_n, probe_rgb_n;
  logic              locked_n, err_line_n, err_frame_n, frame_done_n, probe_valid_n;
  logic              hs_fall, hs_rise, vs_fall, vs_rise;
  logic              tracking, line_err, frame_err, probe_hit;

  // Sync edges relative to the previous pixel sample
  assign hs_fall  = hs_d & ~hs_in;
  assign hs_rise  = ~hs_d & hs_in;
  assign vs_fall  = vs_d & ~vs_in;
  assign vs_rise  = ~vs_d & vs_in;
  assign tracking = (state == TRACK) | (state == LOCKED);
  assign good_inc = good + 1'b1;

  // Line errors: length at hs fall, width at hs rise, counter hitting saturation
  assign line_err = pix_en & (state != SEARCH) &
                    ((hs_fall & (h_cnt != H_LAST)) |
                     (hs_rise & (hs_low != H_SYNC_L)) |
                     (~hs_fall & (h_cnt == CNT_PRE)));

  // Frame errors: length at vs fall, width at vs rise, line counter saturation
  assign frame_err = pix_en & tracking &
                     ((vs_fall & (v_cnt != V_LAST)) |
                      (vs_rise & (vs_low != V_SYNC_L)) |
                      (hs_fall & ~vs_fall & (v_cnt == CNT_PRE)));

  // Probe matches on the pre-update position, i.e. the previously sampled pixel
  assign probe_hit = tracking & (h_cnt == probe_x) & (v_cnt == probe_y);

  // Next-state, counter and output logic
  always_comb begin
    state_n       = state;
    hs_d_n        = hs_d;
    vs_d_n        = vs_d;
    h_cnt_n       = h_cnt;
    v_cnt_n       = v_cnt;
    hs_low_n      = hs_low;
    vs_low_n      = vs_low;
    good_n        = good;
    rgb_d_n       = rgb_d;
    probe_rgb_n   = probe_rgb;
    locked_n      = locked;
    err_line_n    = 1'b0;
    err_frame_n   = 1'b0;
    frame_done_n  = 1'b0;
    probe_valid_n = 1'b0;
    if (pix_en) begin
      hs_d_n  = hs_in;
      vs_d_n  = vs_in;
      rgb_d_n = rgb_in;

      if (hs_fall) h_cnt_n = '0;
      else if (h_cnt != CNT_MAX) h_cnt_n = h_cnt + 1'b1;

      if (hs_fall) hs_low_n = CNT_W'(1);
      else if (!hs_in && hs_low != CNT_MAX) hs_low_n = hs_low + 1'b1;

      if (hs_fall) begin
        if (vs_fall) v_cnt_n = '0;
        else if (v_cnt != CNT_MAX) v_cnt_n = v_cnt + 1'b1;
      end

      if (vs_fall) vs_low_n = hs_fall ? CNT_W'(1) : '0;
      else if (hs_fall && !vs_in && vs_low != CNT_MAX) vs_low_n = vs_low + 1'b1;

      err_line_n   = line_err;
      err_frame_n  = frame_err;
      frame_done_n = tracking & vs_fall;
      if (probe_hit) begin
        probe_valid_n = 1'b1;
        probe_rgb_n   = rgb_d;
      end

      case (state)
        SEARCH: if (hs_fall) state_n = WAIT_V;
        WAIT_V: begin
          if (line_err) state_n = SEARCH;
          else if (vs_fall) begin
            state_n = TRACK;
            good_n  = '0;
          end
        end
        TRACK: begin
          if (line_err || frame_err) state_n = SEARCH;
          else if (vs_fall) begin
            good_n = good_inc;
            if (good_inc == LOCK_L) state_n = LOCKED;
          end
        end
        LOCKED: if (line_err || frame_err) state_n = SEARCH;
        default: state_n = SEARCH;
      endcase

      locked_n = (state_n == LOCKED);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      h_cnt       <= '0;
      v_cnt       <= '0;
      hs_low      <= '0;
      vs_low      <= '0;
      good        <= '0;
      rgb_d       <= '0;
      probe_rgb   <= '0;
      locked      <= 1'b0;
      err_line    <= 1'b0;
      err_frame   <= 1'b0;
      frame_done  <= 1'b0;
      probe_valid <= 1'b0;
    end else begin
      state       <= state_n;
      hs_d        <= hs_d_n;
      vs_d        <= vs_d_n;
      h_cnt       <= h_cnt_n;
      v_cnt       <= v_cnt_n;
      hs_low      <= hs_low_n;
      vs_low      <= vs_low_n;
      good        <= good_n;
      rgb_d       <= rgb_d_n;
      probe_rgb   <= probe_rgb_n;
      locked      <= locked_n;
      err_line    <= err_line_n;
      err_frame   <= err_frame_n;
      frame_done  <= frame_done_n;
      probe_valid <= probe_valid_n;
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor: scaled-down timing, random pixel-strobe gaps,
// behavioural reference model checked every clock, plus scenario pins.
module tb_vga_timing_monitor;

  localparam int H_TOTAL     = 40;
  localparam int H_SYNC      = 6;
  localparam int V_TOTAL     = 12;
  localparam int V_SYNC      = 2;
  localparam int LOCK_FRAMES = 2;

  logic       clk = 1'b0;
  logic       reset, pix_en, hs_in, vs_in;
  logic [7:0] rgb_in;
  logic [9:0] probe_x, probe_y;
  logic [9:0] h_cnt, v_cnt;
  logic       locked, err_line, err_frame, frame_done, probe_valid;
  logic [7:0] probe_rgb;

  int checks = 0;
  int errors = 0;
  int n_el = 0, n_ef = 0, n_fd = 0, n_pv = 0;
  int b_el, b_ef, b_fd, b_pv;

  vga_timing_monitor #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .V_TOTAL(V_TOTAL),
    .V_SYNC(V_SYNC), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hs_in(hs_in), .vs_in(vs_in),
    .rgb_in(rgb_in), .probe_x(probe_x), .probe_y(probe_y),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .locked(locked), .err_line(err_line),
    .err_frame(err_frame), .frame_done(frame_done), .probe_rgb(probe_rgb),
    .probe_valid(probe_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_SEARCH, M_WAITV, M_TRACK, M_LOCKED} mstate_t;
  mstate_t    ms, ms_n;
  logic       m_hs_d, m_vs_d;
  int         m_h, m_v, m_hlow, m_vlow, m_good, nh, nv;
  logic [7:0] m_rgb_prev;
  bit         hf, hr, vf, vr, le, fe, act, trk;
  int         e_h, e_v;
  logic       e_locked, e_el, e_ef, e_fd, e_pv;
  logic [7:0] e_prgb;

  function automatic int sat(input int x);
    return (x > 1023) ? 1023 : x;
  endfunction

  // Per-sample model: counters as unbounded ints clipped at 1023
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ms = M_SEARCH; m_hs_d = 1'b1; m_vs_d = 1'b1;
      m_h = 0; m_v = 0; m_hlow = 0; m_vlow = 0; m_good = 0; m_rgb_prev = 8'h00;
      e_h = 0; e_v = 0; e_locked = 1'b0; e_el = 1'b0; e_ef = 1'b0;
      e_fd = 1'b0; e_pv = 1'b0; e_prgb = 8'h00;
    end else begin
      e_el = 1'b0; e_ef = 1'b0; e_fd = 1'b0; e_pv = 1'b0;
      if (pix_en) begin
        hf  = m_hs_d && !hs_in;
        hr  = !m_hs_d && hs_in;
        vf  = m_vs_d && !vs_in;
        vr  = !m_vs_d && vs_in;
        act = (ms != M_SEARCH);
        trk = (ms == M_TRACK) || (ms == M_LOCKED);
        nh  = hf ? 0 : sat(m_h + 1);
        nv  = hf ? (vf ? 0 : sat(m_v + 1)) : m_v;
        le  = act && ((hf && (m_h + 1 != H_TOTAL)) || (hr && (m_hlow != H_SYNC)) ||
                      (nh == 1023 && m_h != 1023));
        fe  = trk && ((vf && (m_v + 1 != V_TOTAL)) || (vr && (m_vlow != V_SYNC)) ||
                      (nv == 1023 && m_v != 1023));
        e_el = le;
        e_ef = fe;
        e_fd = trk && vf;
        if (trk && m_h == int'(probe_x) && m_v == int'(probe_y)) begin
          e_pv   = 1'b1;
          e_prgb = m_rgb_prev;
        end
        ms_n = ms;
        case (ms)
          M_SEARCH: if (hf) ms_n = M_WAITV;
          M_WAITV:  if (le) ms_n = M_SEARCH;
                    else if (vf) begin ms_n = M_TRACK; m_good = 0; end
          default: begin
            if (le || fe) ms_n = M_SEARCH;
            else if (vf && ms == M_TRACK) begin
              m_good++;
              if (m_good == LOCK_FRAMES) ms_n = M_LOCKED;
            end
          end
        endcase
        ms = ms_n;
        m_hlow = hf ? 1 : (!hs_in ? sat(m_hlow + 1) : m_hlow);
        m_vlow = vf ? (hf ? 1 : 0) : ((hf && !vs_in) ? sat(m_vlow + 1) : m_vlow);
        m_h = nh;
        m_v = nv;
        m_hs_d = hs_in;
        m_vs_d = vs_in;
        m_rgb_prev = rgb_in;
        e_h = m_h;
        e_v = m_v;
        e_locked = (ms == M_LOCKED);
      end
    end
  end

  // Compare every output against the model, away from the active edge
  always @(negedge clk) begin
    check("h_cnt",       32'(h_cnt),       32'(e_h));
    check("v_cnt",       32'(v_cnt),       32'(e_v));
    check("locked",      32'(locked),      32'(e_locked));
    check("err_line",    32'(err_line),    32'(e_el));
    check("err_frame",   32'(err_frame),   32'(e_ef));
    check("frame_done",  32'(frame_done),  32'(e_fd));
    check("probe_valid", 32'(probe_valid), 32'(e_pv));
    check("probe_rgb",   32'(probe_rgb),   32'(e_prgb));
  end

  // Pulse counters used by scenario pins
  always @(negedge clk) begin
    if (err_line)    n_el++;
    if (err_frame)   n_ef++;
    if (frame_done)  n_fd++;
    if (probe_valid) n_pv++;
  end

  // ---------------- stimulus ----------------
  task automatic idle_clk();
    pix_en = 1'b0;
    hs_in  = 1'($urandom);
    vs_in  = 1'($urandom);
    rgb_in = 8'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic pixel(input logic hs, input logic vs, input logic [7:0] rgb);
    repeat ($urandom_range(1, 3)) idle_clk();
    pix_en = 1'b1; hs_in = hs; vs_in = vs; rgb_in = rgb;
    @(posedge clk); #1;
    pix_en = 1'b0;
  endtask

  task automatic frame(input int n_lines, input int short_line, input int hsw_line,
                       input int hsw, input bit pattern);
    for (int l = 0; l < n_lines; l++) begin
      int len, w;
      len = (l == short_line) ? H_TOTAL - 1 : H_TOTAL;
      w   = (l == hsw_line) ? hsw : H_SYNC;
      for (int p = 0; p < len; p++) begin
        logic [7:0] c;
        if (pattern) c = (l == int'(probe_y) && p == int'(probe_x)) ? 8'hE0 : 8'h1C;
        else c = 8'($urandom);
        pixel((p >= w) ? 1'b1 : 1'b0, (l >= V_SYNC) ? 1'b1 : 1'b0, c);
      end
    end
  endtask

  task automatic good_frames(input int n);
    repeat (n) frame(V_TOTAL, -1, -1, 0, 1'b0);
  endtask

  task automatic settle();
    repeat (2) idle_clk();
  endtask

  task automatic snap();
    b_el = n_el; b_ef = n_ef; b_fd = n_fd; b_pv = n_pv;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_h_cnt"},       32'(h_cnt),       32'd0);
    check({tag, "_v_cnt"},       32'(v_cnt),       32'd0);
    check({tag, "_locked"},      32'(locked),      32'd0);
    check({tag, "_err_line"},    32'(err_line),    32'd0);
    check({tag, "_err_frame"},   32'(err_frame),   32'd0);
    check({tag, "_frame_done"},  32'(frame_done),  32'd0);
    check({tag, "_probe_rgb"},   32'(probe_rgb),   32'd0);
    check({tag, "_probe_valid"}, 32'(probe_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; pix_en = 1'b0; hs_in = 1'b1; vs_in = 1'b1; rgb_in = 8'h00;
    probe_x = 10'd20; probe_y = 10'd5;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    reset = 1'b0;

    // Nominal: stream picked up mid-line, lock on 3rd vs fall after WAIT_V
    repeat (5) pixel(1'b1, 1'b1, 8'h00);
    snap();
    good_frames(3);
    settle();
    check("t1_not_yet_locked", 32'(locked), 32'd0);
    good_frames(3);
    settle();
    check("t1_locked",     32'(locked), 32'd1);
    check("t1_frame_done", 32'(n_fd - b_fd), 32'd4);
    check("t1_err_line",   32'(n_el - b_el), 32'd0);
    check("t1_err_frame",  32'(n_ef - b_ef), 32'd0);

    // Short line while locked
    snap();
    frame(V_TOTAL, 7, -1, 0, 1'b0);
    settle();
    check("t2_err_line",  32'(n_el - b_el), 32'd1);
    check("t2_err_frame", 32'(n_ef - b_ef), 32'd0);
    check("t2_unlocked",  32'(locked), 32'd0);
    good_frames(3);
    settle();
    check("t2_relocked",  32'(locked), 32'd1);

    // hs width one short while locked
    snap();
    frame(V_TOTAL, -1, 4, H_SYNC - 1, 1'b0);
    settle();
    check("t3_err_line", 32'(n_el - b_el), 32'd1);
    check("t3_unlocked", 32'(locked), 32'd0);
    good_frames(3);
    settle();
    check("t3_relocked", 32'(locked), 32'd1);

    // Probe at (20,5) with a single marked pixel
    snap();
    frame(V_TOTAL, -1, -1, 0, 1'b1);
    settle();
    check("t4_probe_valid", 32'(n_pv - b_pv), 32'd1);
    check("t4_probe_rgb",   32'(probe_rgb), 32'hE0);
    check("t4_frame_done",  32'(n_fd - b_fd), 32'd1);

    // hs stuck high: single timeout error, then relock
    snap();
    frame(3, -1, -1, 0, 1'b0);
    repeat (1100) pixel(1'b1, 1'b1, 8'($urandom));
    settle();
    check("t5_err_line",  32'(n_el - b_el), 32'd1);
    check("t5_err_frame", 32'(n_ef - b_ef), 32'd0);
    check("t5_h_sat",     32'(h_cnt), 32'd1023);
    check("t5_unlocked",  32'(locked), 32'd0);
    good_frames(4);
    settle();
    check("t5_relocked",  32'(locked), 32'd1);

    // Reset mid-frame: immediate clear, full relock sequence
    frame(5, -1, -1, 0, 1'b0);
    reset = 1'b1;
    #1;
    all_zero("t6_async");
    repeat (3) idle_clk();
    reset = 1'b0;
    good_frames(3);
    settle();
    check("t6_not_yet_locked", 32'(locked), 32'd0);
    good_frames(1);
    settle();
    check("t6_relocked", 32'(locked), 32'd1);

    // Random frames: random probes, occasional line-length and hs-width faults
    for (int f = 0; f < 6; f++) begin
      int sl, hl, hw;
      probe_x = 10'($urandom_range(0, H_TOTAL - 1));
      probe_y = 10'($urandom_range(0, V_TOTAL - 1));
      sl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, V_TOTAL - 1)) : -1;
      hl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, V_TOTAL - 1)) : -1;
      hw = ($urandom_range(0, 1) == 1) ? H_SYNC + 1 : H_SYNC - 1;
      frame(V_TOTAL, sl, hl, hw, 1'b0);
    end
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
